fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and issue stage that drives the control unit's opcode input and consumes its branch decision (`pcSrc`, `C_offset`). It holds the program counter and requests instruction words from instruction memory over a req/ack handshake. It buffers returned words in a small prefetch queue and presents one instruction at a time to decode. On a taken branch it redirects the PC, flushes the queue and discards any in-flight response.

## Interface
- `ADDR_W`, 16, instruction word-address width
- `INSTR_W`, 32, instruction width; opcode is `instr[INSTR_W-1 -: 5]`
- `OFF_W`, 16, branch immediate width (sign-extended to `ADDR_W`)
- `RESET_PC`, 0, PC value loaded on reset
- `CLK`  in  1  single clock, rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  word address of request
- `imem_ack`  in  1  response strobe, one cycle, carries `imem_rdata`
- `imem_rdata`  in  INSTR_W  instruction word
- `instr_valid`  out  1  head instruction available
- `instr_ready`  in  1  decode accepts head this cycle
- `instr`  out  INSTR_W  head instruction word
- `opcode`  out  5  head opcode field, to control unit
- `pc_out`  out  ADDR_W  address of head instruction
- `pcSrc`  in  1  branch taken for head instruction
- `C_offset`  in  1  0: PC-relative target, 1: absolute register target
- `branch_off`  in  OFF_W  immediate offset
- `branch_reg`  in  ADDR_W  register target

## Operation
- Queue depth `DEPTH` = 2 (see Configuration). Each entry holds {word, address}.
- Request issue: `imem_req` rises when `count + outstanding < DEPTH` and no request is pending. `imem_addr` = `fetch_pc`. Both stay stable until the `imem_ack` cycle. At most 1 request is outstanding.
- On `imem_ack` with a live request, push {`imem_rdata`, `imem_addr`} and set `fetch_pc += 1` (wraps modulo 2^ADDR_W). `imem_ack` with no outstanding request is ignored.
- Issue: head shown on `instr`/`opcode`/`pc_out` with `instr_valid`=1 while count>0. Pop when `instr_valid & instr_ready`.
- Redirect occurs when `instr_valid & instr_ready & pcSrc`:
  - target = `C_offset` ? `branch_reg` : `pc_out + 1 + sext(branch_off)`, mod 2^ADDR_W.
  - `fetch_pc` ← target; queue flushed (count←0).
  - If a request is outstanding, set `drop`. The next ack is discarded, `drop` clears and `fetch_pc` is unchanged. `imem_req` deasserts the cycle after redirect and re-asserts only after the dropped ack.
- `pcSrc` is ignored when no pop occurs.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `opcode`=0, `pc_out`=0, `fetch_pc`=RESET_PC, count=0, `drop`=0.
- First `imem_req` is asserted 1 cycle after `RESET` deasserts.
- Latency: an ack at edge N produces `instr_valid`=1 after edge N (registered, no bypass from `imem_rdata`).
- Simultaneous push and pop: count unchanged. This is legal at full.
- Simultaneous ack and redirect: the acked word is discarded, no `drop` is set (request consumed), and the next request goes to the target the following cycle.
- `RESET` mid-transaction forces all reset values immediately. A late ack after reset release is ignored, because no request is outstanding.
- Steady-state throughput is 1 instr per 2 cycles with a 1-cycle memory (the request is re-evaluated after each ack).

## Configuration
- `FETCH_PREFETCH_EN` defined: DEPTH=2, so a fetch can proceed while the head is stalled.
- Undefined: DEPTH=1 single holding register. A request is issued only when empty (or popped in the same cycle). Redirect and drop behaviour are identical.

## Test plan
- Reset, RESET_PC=0, 1-cycle ack memory, `instr_ready`=1 -> addresses 0,1,2 fetched in order; `pc_out` 0,1,2 with matching `opcode`.
- `instr_ready`=0 for 10 cycles -> with macro, exactly 2 words buffered and `imem_req` low; without macro, 1 word.
- Head at pc 5 with `pcSrc`=1, `C_offset`=0, `branch_off`=-3 -> next `imem_addr`=3 and queued pc 6 is flushed.
- Redirect with `C_offset`=1, `branch_reg`=0x0040 while a request to 7 is outstanding -> ack for 7 is discarded, then request 0x0040 is issued.
- `fetch_pc`=0xFFFF -> next address 0x0000; an ack arriving with `imem_req`=0 causes no push.
- Assert `RESET` with a request pending and 2 entries queued -> all outputs take reset values asynchronously, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, imem req/ack fetch and issue queue for decode.
// Macro FETCH_PREFETCH_EN selects a 2-entry prefetch queue; undefined gives one holding register.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 32,
    parameter int OFF_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               pcSrc,
    input  logic               C_offset,
    input  logic [OFF_W-1:0]   branch_off,
    input  logic [ADDR_W-1:0]  branch_reg
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic [ADDR_W-1:0]  fetch_pc;
    logic               req_q;
    logic               drop_q;
    logic [1:0]         count;
    logic               req_nxt;
    logic               drop_nxt;
    logic [1:0]         count_nxt;
    logic               pop;
    logic               redirect;
    logic               push;
    logic               slot_head;
    logic [ADDR_W-1:0]  target;
    logic [INSTR_W-1:0] head_word;
    logic [ADDR_W-1:0]  head_addr;
`ifdef FETCH_PREFETCH_EN
    logic [INSTR_W-1:0] tail_word;
    logic [ADDR_W-1:0]  tail_addr;
`endif

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign redirect    = pop & pcSrc;
    // An acked word is only kept when it answers a live request and no branch
    // is flushing the queue in the same cycle.
    assign push        = imem_ack & req_q & ~redirect;
    // A pushed word lands at the head when the queue is (or becomes) empty.
    assign slot_head   = (count == 2'd0) || ((count == 2'd1) && pop);

    assign target = C_offset ? branch_reg
                  : pc_out + ADDR_W'(1) + ADDR_W'($signed(branch_off));

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc;
    assign instr     = head_word;
    assign opcode    = head_word[INSTR_W-1 -: 5];
    assign pc_out    = head_addr;

    // Next occupancy, request and drop state.
    always_comb begin
        count_nxt = count;
        drop_nxt  = drop_q;
        req_nxt   = req_q;
        if (redirect)
            count_nxt = 2'd0;
        else if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
        if (redirect)
            drop_nxt = (req_q | drop_q) & ~imem_ack;
        else if (imem_ack)
            drop_nxt = 1'b0;
        // The request is re-evaluated only in a cycle with nothing in flight.
        if (req_q)
            req_nxt = ~imem_ack & ~redirect;
        else if (drop_q)
            req_nxt = 1'b0;
        else
            req_nxt = (count_nxt < DEPTH);
    end

    // Fetch PC, handshake and occupancy registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
            count    <= 2'd0;
        end else begin
            req_q  <= req_nxt;
            drop_q <= drop_nxt;
            count  <= count_nxt;
            if (redirect)
                fetch_pc <= target;
            else if (push)
                fetch_pc <= fetch_pc + ADDR_W'(1);
        end
    end

    // Queue storage: head entry shifts from the tail on pop.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_word <= '0;
            head_addr <= '0;
`ifdef FETCH_PREFETCH_EN
            tail_word <= '0;
            tail_addr <= '0;
`endif
        end else begin
`ifdef FETCH_PREFETCH_EN
            if (pop) begin
                head_word <= tail_word;
                head_addr <= tail_addr;
            end
            if (push && !slot_head) begin
                tail_word <= imem_rdata;
                tail_addr <= imem_addr;
            end
`endif
            if (push && slot_head) begin
                head_word <= imem_rdata;
                head_addr <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a behavioural imem model.
// Build with or without FETCH_PREFETCH_EN; the bench adapts its queue depth.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 32;
    localparam int OFF_W = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [15:0] pc_out;
    logic        pcSrc = 1'b0;
    logic        C_offset = 1'b0;
    logic [15:0] branch_off = '0;
    logic [15:0] branch_reg = '0;

    fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W), .RESET_PC(RESET_PC)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .pc_out(pc_out),
        .pcSrc(pcSrc), .C_offset(C_offset),
        .branch_off(branch_off), .branch_reg(branch_reg)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err = 0;

    bit          mem_en = 1'b1;
    bit          mem_stall = 1'b0;
    bit          spur_en = 1'b0;
    int          mem_dly = 0;
    bit          mem_pending = 1'b0;
    logic [15:0] mem_paddr = '0;
    int          mem_wait = 0;

    typedef struct {
        logic [15:0] start;
        logic        c;
        logic [15:0] off;
        logic [15:0] breg;
        logic [15:0] exp_addr;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] mem_word(logic [15:0] a);
        return {a[4:0] ^ 5'h15, 11'h5a5, a};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Instruction memory: captures the address when a request appears and
    // answers after a random wait; optionally strobes ack with nothing asked.
    always begin
        @(posedge CLK);
        #1;
        if (!mem_en) begin
            mem_pending = 1'b0;
        end else if (RESET) begin
            mem_pending = 1'b0;
            imem_ack = 1'b0;
        end else begin
            if (imem_ack) mem_pending = 1'b0;
            imem_ack = 1'b0;
            if (!mem_pending && imem_req) begin
                mem_pending = 1'b1;
                mem_paddr = imem_addr;
                mem_wait = int'($urandom_range(mem_dly, 0));
            end
            if (mem_pending) begin
                if (imem_req) chk("imem_addr_stable", 32'(imem_addr), 32'(mem_paddr));
                if (!mem_stall) begin
                    if (mem_wait == 0) begin
                        imem_ack = 1'b1;
                        imem_rdata = mem_word(mem_paddr);
                    end else begin
                        mem_wait--;
                    end
                end
            end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hdead_0000 | 32'($urandom_range(65535, 0));
            end
        end
    end

    task automatic do_reset();
        RESET = 1'b1;
        instr_ready = 1'b0;
        pcSrc = 1'b0;
        C_offset = 1'b0;
        branch_off = '0;
        branch_reg = '0;
        mem_stall = 1'b0;
        mem_en = 1'b1;
        imem_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
    endtask

    task automatic wait_valid(string name);
        int k = 0;
        while (!instr_valid && k < 50) begin
            tick();
            k++;
        end
        chk({name, "_valid_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(string name);
        int k = 0;
        while (!imem_req && k < 50) begin
            tick();
            k++;
        end
        chk({name, "_req_timeout"}, 32'(imem_req), 32'd1);
    endtask

    task automatic expect_head(string name, logic [15:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        wait_valid(name);
        chk({name, "_pc"}, 32'(pc_out), 32'(pc));
        chk({name, "_instr"}, instr, w);
        chk({name, "_opcode"}, 32'(opcode), 32'(w[31:27]));
    endtask

    task automatic expect_stream(string name, logic [15:0] start, int n);
        for (int k = 0; k < n; k++) begin
            expect_head(name, start + 16'(k));
            tick();
        end
    endtask

    task automatic jump_to(logic [15:0] a);
        wait_valid("jump_head");
        C_offset = 1'b1;
        branch_reg = a;
        pcSrc = 1'b1;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        pcSrc = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_pc;
        logic [31:0] w;
        int pops;
        int nv;
        int n;

        vecs[0] = '{16'h0005, 1'b0, 16'hFFFD, 16'h0000, 16'h0003};
        vecs[1] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0010, 1'b1, 16'h1234, 16'h0040, 16'h0040};
        vecs[3] = '{16'h8000, 1'b0, 16'h8000, 16'h0000, 16'h0001};
        vecs[4] = '{16'h1234, 1'b0, 16'h0100, 16'hFFFF, 16'h1335};
        vecs[5] = '{16'h0030, 1'b1, 16'h0005, 16'hFFF0, 16'hFFF0};

        // Reset state and first request.
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        RESET = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'(RESET_PC));

        // In-order fetch and throughput with a 1-cycle memory.
        instr_ready = 1'b1;
        expect_stream("inorder", RESET_PC, 3);
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            nv += int'(instr_valid);
            tick();
        end
        chk("throughput", 32'(nv), 32'd10);

        // Stall decode: queue fills to its depth and requests stop.
        do_reset();
        repeat (10) tick();
        chk("stall_req_low", 32'(imem_req), 32'd0);
        mem_en = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        n = 0;
        while (instr_valid && n < 5) begin
            chk("stall_pc", 32'(pc_out), 32'(RESET_PC + 16'(n)));
            n++;
            tick();
        end
        chk("stall_buffered", 32'(n), 32'(DEPTH));
        instr_ready = 1'b0;

        // Branch target table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            jump_to(vecs[i].start);
            expect_head("vec_start", vecs[i].start);
            C_offset = vecs[i].c;
            branch_off = vecs[i].off;
            branch_reg = vecs[i].breg;
            pcSrc = 1'b1;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            pcSrc = 1'b0;
            wait_req("vec_target");
            chk("vec_target_addr", 32'(imem_addr), 32'(vecs[i].exp_addr));
            expect_head("vec_target_head", vecs[i].exp_addr);
        end

`ifdef FETCH_PREFETCH_EN
        // Redirect while a request is outstanding: its ack is dropped.
        do_reset();
        jump_to(16'h0006);
        expect_head("drop_head", 16'h0006);
        mem_stall = 1'b1;
        tick();
        chk("drop_req7", 32'(imem_req), 32'd1);
        chk("drop_addr7", 32'(imem_addr), 32'h7);
        C_offset = 1'b1;
        branch_reg = 16'h0040;
        pcSrc = 1'b1;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        pcSrc = 1'b0;
        chk("drop_req_low", 32'(imem_req), 32'd0);
        tick();
        tick();
        chk("drop_req_wait", 32'(imem_req), 32'd0);
        mem_stall = 1'b0;
        wait_req("drop_reissue");
        chk("drop_new_addr", 32'(imem_addr), 32'h40);
        expect_head("drop_new_head", 16'h0040);

        // Ack and redirect in the same cycle: no drop, target fetched next.
        do_reset();
        jump_to(16'h0020);
        expect_head("same_head", 16'h0020);
        tick();
        chk("same_req", 32'(imem_req), 32'd1);
        chk("same_addr", 32'(imem_addr), 32'h21);
        C_offset = 1'b0;
        branch_off = 16'd10;
        pcSrc = 1'b1;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        pcSrc = 1'b0;
        chk("same_req_low", 32'(imem_req), 32'd0);
        tick();
        chk("same_req_target", 32'(imem_req), 32'd1);
        chk("same_addr_target", 32'(imem_addr), 32'h2B);
        expect_head("same_target_head", 16'h002B);
`endif

        // Fetch PC wraps past the top of the address space.
        do_reset();
        jump_to(16'hFFFE);
        instr_ready = 1'b1;
        expect_stream("wrap", 16'hFFFE, 3);
        instr_ready = 1'b0;

        // Asynchronous reset mid-transaction, then a late ack is ignored.
        do_reset();
        expect_head("mid_head", RESET_PC);
        mem_stall = 1'b1;
        tick();
        RESET = 1'b1;
        mem_en = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'(RESET_PC));
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_opcode", 32'(opcode), 32'd0);
        chk("async_pc", 32'(pc_out), 32'd0);
        mem_stall = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_addr", 32'(imem_addr), 32'(RESET_PC));
        mem_en = 1'b1;
        expect_head("restart_head", RESET_PC);

        // Random traffic against a program-order reference model.
        do_reset();
        mem_dly = 2;
        spur_en = 1'b1;
        exp_pc = RESET_PC;
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready = 1'($urandom_range(1, 0));
            pcSrc = ($urandom_range(3, 0) == 0);
            C_offset = 1'($urandom_range(1, 0));
            branch_off = 16'($urandom);
            branch_reg = 16'($urandom);
            if (instr_valid && instr_ready) begin
                w = mem_word(exp_pc);
                chk("rand_pc", 32'(pc_out), 32'(exp_pc));
                chk("rand_instr", instr, w);
                if (pcSrc)
                    exp_pc = C_offset ? branch_reg
                           : 16'(int'(exp_pc) + 1 + int'($signed(branch_off)));
                else
                    exp_pc = exp_pc + 16'd1;
                pops++;
            end
            tick();
        end
        instr_ready = 1'b0;
        pcSrc = 1'b0;
        spur_en = 1'b0;
        chk("rand_progress", 32'(pops >= 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
